// File: rtl/ram_pkg.sv
// Shared types and defaults for the latency-modelled main-memory backend.
// Default depth/latency here are also what the cache bench builds against.
package ram_pkg;

    localparam int WORD_W      = 32;
    localparam int RAM_DEPTH   = 1024;
    localparam int RAM_ADDR_W  = $clog2(RAM_DEPTH);
    localparam int RAM_LATENCY = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter must hold LATENCY-1; keep at least one bit when LATENCY is 1.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/ram_backend_if.sv
// Request/response bundle between the cache (master) and ram_backend (slave).
// err exists only when RAM_RANGE_CHECK_EN is defined.
interface ram_backend_if
    import ram_pkg::*;
;
    logic              req;
    logic              wr;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
    logic              busy;
    logic              response;
    logic [WORD_W-1:0] out;
`ifdef RAM_RANGE_CHECK_EN
    logic              err;
`endif

    modport master (
        output req, wr, addr, data,
        input  busy, response, out
`ifdef RAM_RANGE_CHECK_EN
        , input err
`endif
    );

    modport slave (
        input  req, wr, addr, data,
        output busy, response, out
`ifdef RAM_RANGE_CHECK_EN
        , output err
`endif
    );

endinterface

// File: rtl/ram_array.sv
// Single-port synchronous word storage with registered read data.
// Contents are intentionally not reset.
module ram_array
    import ram_pkg::*;
#(
    parameter int DEPTH  = RAM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_backend.sv
// Fixed-latency main-memory model: one request in flight, response pulse on completion.
// Optional RAM_RANGE_CHECK_EN adds err for addresses with bits above ADDR_W set.
//
//   state | meaning
//   IDLE  | busy=0, accepts req on the next edge
//   BUSY  | counting down; access and response on the edge where cnt==0
module ram_backend
    import ram_pkg::*;
#(
    parameter int DEPTH   = RAM_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int LATENCY = RAM_LATENCY
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_backend_if.slave bus
);

    localparam int CNT_W = cnt_width(LATENCY);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept, complete;

    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] data_q;
    logic              response_q;
    logic [WORD_W-1:0] out_q;

    logic              we;
    logic [ADDR_W-1:0] raddr;
    logic [WORD_W-1:0] rdata;
    logic [WORD_W-1:0] rd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef RAM_RANGE_CHECK_EN
    logic hi_bad_q;
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_bad_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                hi_bad_q <= |bus.addr[WORD_W-1:ADDR_W];
            end
            err_q <= complete & hi_bad_q;
        end
    end

    assign we      = complete & wr_q & ~hi_bad_q;
    assign rd_word = hi_bad_q ? '0 : rdata;
    assign bus.err = err_q;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[WORD_W-1:ADDR_W];

    assign we      = complete & wr_q;
    assign rd_word = rdata;
`endif

    // In IDLE the array is pre-addressed from the bus so a LATENCY of 1 still
    // sees the requested word one edge after acceptance.
    assign raddr = (state == IDLE) ? bus.addr[ADDR_W-1:0] : addr_q;

    ram_array #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .waddr(addr_q),
        .raddr(raddr),
        .wdata(data_q),
        .rdata(rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            response_q <= 1'b0;
            out_q      <= '0;
        end else begin
            response_q <= complete;
            if (accept) begin
                wr_q   <= bus.wr;
                addr_q <= bus.addr[ADDR_W-1:0];
                data_q <= bus.data;
            end
            if (complete && !wr_q) begin
                out_q <= rd_word;
            end
        end
    end

    assign bus.busy     = (state == BUSY);
    assign bus.response = response_q;
    assign bus.out      = out_q;

endmodule

// File: tb/tb_ram_backend.sv
// Scoreboard bench for ram_backend: stimulus pushes expected responses, a
// negedge monitor pops and checks them (define RAM_RANGE_CHECK_EN to test err).
module tb_ram_backend;
    import ram_pkg::*;

    localparam int LAT = RAM_LATENCY;

`ifdef RAM_RANGE_CHECK_EN
    localparam logic [31:0] ALIAS_OUT = 32'h0;
    localparam logic        ALIAS_ERR = 1'b1;
    localparam logic [31:0] ALIAS_RD  = 32'h0000_0001;
`else
    localparam logic [31:0] ALIAS_OUT = 32'hDEAD_BEEF;
    localparam logic        ALIAS_ERR = 1'b0;
    localparam logic [31:0] ALIAS_RD  = 32'h0000_005A;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ram_backend_if bus();

    ram_backend #(
        .DEPTH  (RAM_DEPTH),
        .ADDR_W (RAM_ADDR_W),
        .LATENCY(RAM_LATENCY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] out;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.response === 1'b1) begin
            exp_t e;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_response: response at cycle %0d, expected none", cyc);
            end else begin
                e = q.pop_front();
                check32("resp_cycle", cyc, e.cyc);
                check32("resp_out", bus.out, e.out);
                check32("resp_busy", {31'b0, bus.busy}, 32'd0);
`ifdef RAM_RANGE_CHECK_EN
                check32("resp_err", {31'b0, bus.err}, {31'b0, e.err});
`endif
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: busy=%b expected 0 within 100 cycles", bus.busy);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic push, input logic [31:0] exp_out, input logic exp_err,
                         output int acc);
        wait_idle();
        bus.req  = 1'b1;
        bus.wr   = w;
        bus.addr = a;
        bus.data = d;
        @(posedge clk);
        #1;
        acc      = cyc;
        bus.req  = 1'b0;
        bus.wr   = 1'b0;
        bus.addr = '0;
        bus.data = '0;
        if (push) q.push_back('{acc + LAT, exp_out, exp_err});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check32(name, q.size(), 32'd0);
    endtask

    initial begin
        int acc;
        int acc2;
        bus.req  = 1'b0;
        bus.wr   = 1'b0;
        bus.addr = '0;
        bus.data = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check32("rst_busy", {31'b0, bus.busy}, 32'd0);
        check32("rst_response", {31'b0, bus.response}, 32'd0);
        check32("rst_out", bus.out, 32'd0);

        // write 0x5, busy for LATENCY cycles, out untouched
        issue(1'b1, 32'h5, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, acc);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check32("t1_busy_hi", {31'b0, bus.busy}, 32'd1);
        end
        @(negedge clk);
        check32("t1_busy_lo", {31'b0, bus.busy}, 32'd0);
        check32("t1_out", bus.out, 32'd0);
        drain("t1_drain");

        // read back and hold
        issue(1'b0, 32'h5, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, acc);
        drain("t2_drain");
        repeat (10) @(negedge clk);
        check32("t2_hold", bus.out, 32'hDEAD_BEEF);

        // back-to-back write then read with no gap
        issue(1'b1, 32'h3, 32'h11, 1'b1, 32'hDEAD_BEEF, 1'b0, acc);
        issue(1'b0, 32'h3, 32'h0, 1'b1, 32'h11, 1'b0, acc2);
        check32("t3_no_gap", acc2, acc + LAT + 1);
        drain("t3_drain");

        // req pulse while busy is dropped
        issue(1'b0, 32'h3, 32'h0, 1'b1, 32'h11, 1'b0, acc);
        check32("t4_busy", {31'b0, bus.busy}, 32'd1);
        bus.req  = 1'b1;
        bus.wr   = 1'b1;
        bus.addr = 32'h3;
        bus.data = 32'h99;
        @(posedge clk);
        #1;
        bus.req  = 1'b0;
        bus.wr   = 1'b0;
        bus.addr = '0;
        bus.data = '0;
        issue(1'b0, 32'h3, 32'h0, 1'b1, 32'h11, 1'b0, acc);
        drain("t4_drain");
        repeat (LAT + 2) @(negedge clk);

        // reset aborts an in-flight write
        issue(1'b1, 32'h8, 32'h22, 1'b1, 32'h11, 1'b0, acc);
        drain("t5_pre_drain");
        issue(1'b1, 32'h8, 32'h77, 1'b0, 32'h0, 1'b0, acc);
        repeat (2) @(posedge clk);
        #1;
        check32("t5_busy_before", {31'b0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check32("t5_busy", {31'b0, bus.busy}, 32'd0);
        check32("t5_out", bus.out, 32'd0);
        check32("t5_response", {31'b0, bus.response}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        issue(1'b0, 32'h8, 32'h0, 1'b1, 32'h22, 1'b0, acc);
        drain("t5_drain");

        // upper address bits: alias in default build, err with range check
        issue(1'b0, 32'h405, 32'h0, 1'b1, ALIAS_OUT, ALIAS_ERR, acc);
        drain("t6_rd_drain");
        @(negedge clk);
`ifdef RAM_RANGE_CHECK_EN
        check32("t6_err_drop", {31'b0, bus.err}, 32'd0);
`endif
        issue(1'b1, 32'h00A, 32'h1, 1'b1, ALIAS_OUT, 1'b0, acc);
        issue(1'b1, 32'h40A, 32'h5A, 1'b1, ALIAS_OUT, ALIAS_ERR, acc);
        issue(1'b0, 32'h00A, 32'h0, 1'b1, ALIAS_RD, 1'b0, acc);
        drain("t6_drain");

        repeat (LAT + 4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
